// File: rtl/scan_decoder_n.sv
// Registered active-low 1-of-N decoder with a built-in scan sequencer.
// In auto mode a prescaled counter walks the active-low select across the first NUM_ACTIVE outputs.
module scan_decoder_n #(
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned DIV        = 4,
  parameter int unsigned NUM_ACTIVE = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    blank,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [(2**SEL_W)-1:0]   nf,
  output logic [SEL_W-1:0]        cur,
  output logic                    wrap
);

  localparam int unsigned N      = 2 ** SEL_W;
  localparam int unsigned PreW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(DIV - 1);
  localparam logic [SEL_W:0]  NumAct  = (SEL_W + 1)'(NUM_ACTIVE);
  localparam logic [SEL_W:0]  LastIdx = (SEL_W + 1)'(NUM_ACTIVE - 1);

  logic [PreW-1:0]  pre_q, pre_d;
  logic [SEL_W-1:0] cur_q, cur_d;
  logic             wrap_q, wrap_d;
  logic [N-1:0]     nf_q, nf_d;

  always_comb begin
    pre_d  = pre_q;
    cur_d  = cur_q;
    wrap_d = 1'b0;
    if (mode) begin
      // Manual select also discards any step that would have been due this edge.
      cur_d = sel;
      pre_d = '0;
    end else if (pre_q == PreLast) begin
      pre_d = '0;
      if ({1'b0, cur_q} >= LastIdx) begin
        cur_d  = '0;
        wrap_d = 1'b1;
      end else begin
        cur_d = cur_q + SEL_W'(1);
      end
    end else begin
      pre_d = pre_q + PreW'(1);
    end

    // Decode from the next select so nf and cur change on the same edge.
    nf_d = '1;
    if (!blank && ({1'b0, cur_d} < NumAct)) begin
      nf_d[cur_d] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      cur_q  <= '0;
      wrap_q <= 1'b0;
      nf_q   <= '1;
    end else begin
      pre_q  <= pre_d;
      cur_q  <= cur_d;
      wrap_q <= wrap_d;
      nf_q   <= nf_d;
    end
  end

  assign nf   = nf_q;
  assign cur  = cur_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder_n.sv
// Scoreboard bench for scan_decoder_n: four parameterisations, directed stimulus,
// expected responses queued by the stimulus process and checked by a negedge monitor.
module tb_scan_decoder_n;

  logic clk;
  logic rst;

  logic       blank_a, mode_a, blank_b, mode_b, blank_c, mode_c, blank_d, mode_d;
  logic [1:0] sel_a, sel_b, sel_d;
  logic [2:0] sel_c;
  logic [3:0] nf_a, nf_b, nf_d;
  logic [7:0] nf_c;
  logic [1:0] cur_a, cur_b, cur_d;
  logic [2:0] cur_c;
  logic       wrap_a, wrap_b, wrap_c, wrap_d;

  int tests;
  int fails;

  typedef struct {
    int         id;
    logic [7:0] nf;
    logic [2:0] cur;
    logic       wrap;
    string      tag;
  } exp_t;

  exp_t sb[$];

  // Active-low patterns for select 0..3 in a 4-output decoder.
  logic [3:0] nf4 [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Mode/select transitions on the NUM_ACTIVE=3, DIV=4 instance.
  logic       d_mode [17] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
  logic [1:0] d_sel  [17] = '{2, 2, 3, 3, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0};
  logic [3:0] d_nf   [17] = '{4'b1011, 4'b1011, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
                              4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1011,
                              4'b1011, 4'b1011, 4'b1011, 4'b1110, 4'b1110};
  logic [1:0] d_cur  [17] = '{2, 2, 3, 3, 3, 3, 3, 0, 0, 0, 0, 2, 2, 2, 2, 0, 0};
  logic       d_wrap [17] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};

  scan_decoder_n #(.SEL_W(2), .DIV(4), .NUM_ACTIVE(4)) u_a (
    .clk(clk), .rst(rst), .blank(blank_a), .mode(mode_a), .sel(sel_a),
    .nf(nf_a), .cur(cur_a), .wrap(wrap_a)
  );
  scan_decoder_n #(.SEL_W(2), .DIV(1), .NUM_ACTIVE(3)) u_b (
    .clk(clk), .rst(rst), .blank(blank_b), .mode(mode_b), .sel(sel_b),
    .nf(nf_b), .cur(cur_b), .wrap(wrap_b)
  );
  scan_decoder_n #(.SEL_W(3), .DIV(2), .NUM_ACTIVE(8)) u_c (
    .clk(clk), .rst(rst), .blank(blank_c), .mode(mode_c), .sel(sel_c),
    .nf(nf_c), .cur(cur_c), .wrap(wrap_c)
  );
  scan_decoder_n #(.SEL_W(2), .DIV(4), .NUM_ACTIVE(3)) u_d (
    .clk(clk), .rst(rst), .blank(blank_d), .mode(mode_d), .sel(sel_d),
    .nf(nf_d), .cur(cur_d), .wrap(wrap_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [7:0] nf, input logic [2:0] cur,
                      input logic wrap, input string tag);
    exp_t e;
    e.id   = id;
    e.nf   = nf;
    e.cur  = cur;
    e.wrap = wrap;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " A nf"}, 32'(nf_a), 32'hf);
    check({tag, " A cur"}, 32'(cur_a), 0);
    check({tag, " A wrap"}, 32'(wrap_a), 0);
    check({tag, " B nf"}, 32'(nf_b), 32'hf);
    check({tag, " C nf"}, 32'(nf_c), 32'hff);
    check({tag, " C cur"}, 32'(cur_c), 0);
    check({tag, " D nf"}, 32'(nf_d), 32'hf);
    check({tag, " D cur"}, 32'(cur_d), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: one expected entry per clock, compared away from the active edge.
  exp_t       m_e;
  logic [7:0] m_nf;
  logic [2:0] m_cur;
  logic       m_wrap;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      m_e = sb.pop_front();
      case (m_e.id)
        0:       begin m_nf = {4'h0, nf_a}; m_cur = {1'b0, cur_a}; m_wrap = wrap_a; end
        1:       begin m_nf = {4'h0, nf_b}; m_cur = {1'b0, cur_b}; m_wrap = wrap_b; end
        2:       begin m_nf = nf_c;         m_cur = cur_c;         m_wrap = wrap_c; end
        default: begin m_nf = {4'h0, nf_d}; m_cur = {1'b0, cur_d}; m_wrap = wrap_d; end
      endcase
      check({m_e.tag, " nf"}, 32'(m_nf), 32'(m_e.nf));
      check({m_e.tag, " cur"}, 32'(m_cur), 32'(m_e.cur));
      check({m_e.tag, " wrap"}, 32'(m_wrap), 32'(m_e.wrap));
      if (m_e.id == 2) begin
        check({m_e.tag, " one low"}, 32'($countones(~nf_c)), 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int c;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    {blank_a, mode_a, blank_b, mode_b, blank_c, mode_c, blank_d, mode_d} = '0;
    sel_a = '0; sel_b = '0; sel_c = '0; sel_d = '0;
    @(posedge clk);
    #1 check_reset("init");
    rst = 1'b0;

    // Default scan with a blank window spanning the 3 -> 0 wrap.
    for (int k = 1; k <= 36; k++) begin
      blank_a = (k >= 27 && k <= 32);
      @(posedge clk);
      c = (k / 4) % 4;
      push(0, (k >= 27 && k <= 32) ? 8'h0f : {4'h0, nf4[c]}, 3'(c),
           (k == 16 || k == 32), $sformatf("A e%0d", k));
      #1;
    end

    // Asynchronous reset between edges, then held across an edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset("async");
    @(posedge clk);
    #1 check_reset("hold");
    rst = 1'b0;

    // DIV=1, three active outputs.
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      c = k % 3;
      push(1, {4'h0, nf4[c]}, 3'(c), (k % 3 == 0), $sformatf("B e%0d", k));
      #1;
    end

    pulse_reset();
    // Eight outputs, two clocks per step.
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      c = (k / 2) % 8;
      push(2, ~(8'd1 << c), 3'(c), (k == 16 || k == 32), $sformatf("C e%0d", k));
      #1;
    end

    pulse_reset();
    for (int k = 0; k < 17; k++) begin
      mode_d = d_mode[k];
      sel_d  = d_sel[k];
      @(posedge clk);
      push(3, {4'h0, d_nf[k]}, {1'b0, d_cur[k]}, d_wrap[k], $sformatf("D e%0d", k + 1));
      #1;
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    check("drain", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
